// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the 7-segment readback block.
//   state_t      FSM states of the stability detector
//   SEG_TABLE    active-high {g,f,e,d,c,b,a} patterns for hex digits 0..F
//   SEG_BLANK    all segments off
//   PAT_W        width of the compared pattern (8 when dp is captured)
//   digit_t      queued entry {invalid, hex[, dp]}
//   seg_decode   pattern -> {invalid, hex}
// Optional feature macro: SEG7_DP_CAPTURE_EN (decimal point capture).
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Packed so that index i holds the pattern for hex digit i (list runs F..0).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

`ifdef SEG7_DP_CAPTURE_EN
  localparam int PAT_W = 8;
`else
  localparam int PAT_W = 7;
`endif

  typedef struct packed {
    logic       invalid;
    logic [3:0] hex;
`ifdef SEG7_DP_CAPTURE_EN
    logic       dp;
`endif
  } digit_t;

  localparam int DIGIT_W = $bits(digit_t);

  // Unknown patterns (including blank) return invalid=1, hex=0.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] res;
    res = 5'h10;
    for (int i = 0; i < 16; i++) begin
      if (SEG_TABLE[i] == seg) begin
        res = {1'b0, i[3:0]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seg7_fifo.sv
// seg7_fifo: small first-word-fall-through FIFO.
//   clk, rst     clock, asynchronous active-high reset (clears pointers only)
//   push         write push_data when not full (or when a pop happens too)
//   push_data    entry to write
//   full         DEPTH entries held
//   pop          consume the head; ignored while empty
//   pop_data     current head, valid whenever empty=0
//   empty        no entries held
// DEPTH must be a power of two so the pointers wrap naturally.
module seg7_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          pop_ok;
  logic          push_ok;

  logic [DEPTH-1:0][WIDTH-1:0] entries;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == (AW+1)'(DEPTH));
  assign pop_ok   = pop && !empty;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = entries[rd_ptr_reg];

  // Storage is data-path only; validity is tracked by the pointers.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_reg;
      always_ff @(posedge clk) begin
        if (push_ok && (wr_ptr_reg == AW'(gi))) begin
          entry_reg <= push_data;
        end
      end
      assign entries[gi] = entry_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/seg7_readback.sv
// seg7_readback: reads a 7-segment display pattern back into hex digits.
// The raw pattern is synchronised, must hold steady for STABLE_CYCLES
// samples, is decoded and queued in a FWFT FIFO with valid/ready.
//   clk, rst      clock, asynchronous active-high reset
//   seg_in[6:0]   raw segments {g,f,e,d,c,b,a}, active-high
//   dp_in         decimal point (captured only with SEG7_DP_CAPTURE_EN)
//   digit_data    {invalid, hex[3:0]} of the FIFO head (0 when empty)
//   digit_dp      captured decimal point of the head (0 without the macro)
//   digit_valid   FIFO head valid
//   digit_ready   consumer takes the head when digit_valid && digit_ready
//   overflow      sticky: a new digit was dropped on a full FIFO
//   clr_overflow  synchronous clear of overflow (a new drop wins)
//   busy          detector is waiting for the pattern to settle
// Optional feature macro: SEG7_DP_CAPTURE_EN.
module seg7_readback
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 1000,
  parameter int FIFO_DEPTH    = 4,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic       dp_in,
  output logic [4:0] digit_data,
  output logic       digit_dp,
  output logic       digit_valid,
  input  logic       digit_ready,
  output logic       overflow,
  input  logic       clr_overflow,
  output logic       busy
);

  logic [PAT_W-1:0] raw_pat;
  logic [PAT_W-1:0] sync1_reg;
  logic [PAT_W-1:0] sync2_reg;

`ifdef SEG7_DP_CAPTURE_EN
  assign raw_pat = {dp_in, seg_in};
`else
  logic unused_dp;
  assign raw_pat   = seg_in;
  assign unused_dp = dp_in;
`endif

  // Two-flop synchroniser; everything downstream uses sync2_reg.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= raw_pat;
      sync2_reg <= sync1_reg;
    end
  end

  state_t           state_reg;
  logic [PAT_W-1:0] cand_reg;
  logic [PAT_W-1:0] last_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             busy_reg;
  logic             push_reg;
  digit_t           push_data_reg;
  digit_t           cand_digit;
  logic             cand_is_new;

  always_comb begin
    cand_digit = '0;
    {cand_digit.invalid, cand_digit.hex} = seg_decode(cand_reg[6:0]);
`ifdef SEG7_DP_CAPTURE_EN
    cand_digit.dp = cand_reg[7];
`endif
  end

  // Blank is accepted silently; a candidate equal to the last accepted
  // pattern (possible after a glitch back to it) is never queued again.
  assign cand_is_new = (cand_reg != '0) && (cand_reg != last_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cand_reg      <= '0;
      last_reg      <= PAT_W'(SEG_BLANK);
      cnt_reg       <= '0;
      busy_reg      <= 1'b0;
      push_reg      <= 1'b0;
      push_data_reg <= '0;
    end else begin
      push_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (sync2_reg != last_reg) begin
            state_reg <= SETTLE;
            cand_reg  <= sync2_reg;
            cnt_reg   <= CNT_W'(1);
            busy_reg  <= 1'b1;
          end
        end
        SETTLE: begin
          if (sync2_reg != cand_reg) begin
            cand_reg <= sync2_reg;
            cnt_reg  <= CNT_W'(1);
          end else if (cnt_reg >= CNT_W'(STABLE_CYCLES)) begin
            // push_reg is high during the COMMIT cycle; FIFO writes on its exit edge.
            state_reg     <= COMMIT;
            busy_reg      <= 1'b0;
            push_reg      <= cand_is_new;
            push_data_reg <= cand_digit;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        COMMIT: begin
          last_reg  <= cand_reg;
          cnt_reg   <= '0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  logic               fifo_full;
  logic               fifo_empty;
  logic [DIGIT_W-1:0] head_bits;
  digit_t             head;
  logic               drop;

  seg7_fifo #(
    .WIDTH (DIGIT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_reg),
    .push_data (push_data_reg),
    .full      (fifo_full),
    .pop       (digit_ready),
    .pop_data  (head_bits),
    .empty     (fifo_empty)
  );

  assign head        = digit_t'(head_bits);
  assign digit_valid = !fifo_empty;
  assign digit_data  = fifo_empty ? 5'h00 : {head.invalid, head.hex};
`ifdef SEG7_DP_CAPTURE_EN
  assign digit_dp    = fifo_empty ? 1'b0 : head.dp;
`else
  assign digit_dp    = 1'b0;
`endif

  // A write on a full FIFO survives only if the head is consumed on that edge.
  assign drop = push_reg && fifo_full && !(digit_valid && digit_ready);

  logic overflow_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_reg <= 1'b0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
    end else if (clr_overflow) begin
      overflow_reg <= 1'b0;
    end
  end

  assign overflow = overflow_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_seg7_readback.sv
// tb_seg7_readback: directed bench for seg7_readback with a timestamp-based
// reference model and a per-cycle compare, plus literal expectations.
module tb_seg7_readback;

  localparam int N     = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg_in = 7'h00;
  logic       dp_in = 1'b0;
  logic [4:0] digit_data;
  logic       digit_dp;
  logic       digit_valid;
  logic       digit_ready = 1'b0;
  logic       overflow;
  logic       clr_overflow = 1'b0;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg7_readback #(
    .STABLE_CYCLES (N),
    .FIFO_DEPTH    (DEPTH),
    .CNT_W         (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .seg_in       (seg_in),
    .dp_in        (dp_in),
    .digit_data   (digit_data),
    .digit_dp     (digit_dp),
    .digit_valid  (digit_valid),
    .digit_ready  (digit_ready),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .busy         (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // {dp, invalid, hex}
  function automatic logic [5:0] model_digit(input logic [7:0] p);
    logic [5:0] r;
    r = {p[7], 5'h10};
    for (int i = 0; i < 16; i++)
      if (hex_tbl[i] == p[6:0]) r = {p[7], 1'b0, 4'(i)};
    return r;
  endfunction

  logic [7:0] smp_pat;
  logic       smp_ready;
  logic       smp_clr;
  logic [7:0] h1, h2, last_m, run_m;
  bit         active_m, due_m, ovf_m;
  int         since_m, en_m;
  logic [5:0] mq[$];

  always @(posedge clk) begin
`ifdef SEG7_DP_CAPTURE_EN
    smp_pat = {dp_in, seg_in};
`else
    smp_pat = {1'b0, seg_in};
`endif
    smp_ready = digit_ready;
    smp_clr   = clr_overflow;
  end

  task automatic model_reset();
    h1 = '0; h2 = '0; last_m = '0; run_m = '0;
    active_m = 0; due_m = 0; ovf_m = 0; since_m = 0; en_m = 0;
    mq.delete();
  endtask

  // One clock edge: s is the input seen two edges ago; a run starting at
  // edge 'since_m' is accepted once it has lasted N further edges.
  task automatic model_step();
    logic [7:0] s;
    bit pop_ok, drop;
    int sz;
    en_m++;
    s  = h2;
    h2 = h1;
    h1 = smp_pat;
    sz = mq.size();
    pop_ok = smp_ready && (sz > 0);
    drop = 0;
    if (pop_ok) void'(mq.pop_front());
    if (due_m) begin
      if (run_m != 8'h00 && run_m != last_m) begin
        if (sz < DEPTH || pop_ok) mq.push_back(model_digit(run_m));
        else drop = 1;
      end
      last_m = run_m;
      due_m  = 0;
    end else if (!active_m) begin
      if (s != last_m) begin active_m = 1; run_m = s; since_m = en_m; end
    end else if (s != run_m) begin
      run_m = s; since_m = en_m;
    end else if (en_m - since_m >= N) begin
      active_m = 0; due_m = 1;
    end
    if (drop) ovf_m = 1;
    else if (smp_clr) ovf_m = 0;
  endtask

  // Per-cycle compare, half a cycle after the edge the model just stepped.
  always @(negedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      model_step();
      check("cyc_valid", digit_valid, mq.size() > 0);
      check("cyc_data", digit_data, (mq.size() > 0) ? mq[0][4:0] : 5'h00);
      check("cyc_dp", digit_dp, (mq.size() > 0) ? mq[0][5] : 1'b0);
      check("cyc_overflow", overflow, ovf_m);
      check("cyc_busy", busy, active_m);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic present(input logic [6:0] p);
    seg_in = p;
    cyc(10);
  endtask

  task automatic pop_digit(input logic [4:0] exp, input logic exp_dp, input string name);
    check({name, "_valid"}, digit_valid, 1'b1);
    check({name, "_data"}, digit_data, exp);
    check({name, "_dp"}, digit_dp, exp_dp);
    $display("pop %s data=%02h dp=%0d", name, digit_data, digit_dp);
    digit_ready = 1'b1;
    @(negedge clk);
    digit_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1;
    check("rst_valid", digit_valid, 1'b0);
    check("rst_data", digit_data, 5'h00);
    check("rst_dp", digit_dp, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_busy", busy, 1'b0);
    cyc(2);
    #2 rst = 1'b0;

    // T1: latency and single entry for a held pattern
    @(negedge clk);
    seg_in = 7'h5B;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("t1_latency", digit_valid, k == 8);
    end
    check("t1_data", digit_data, 5'h02);
    cyc(8);
    pop_digit(5'h02, 1'b0, "t1");
    check("t1_single", digit_valid, 1'b0);

    // T2: glitching input never settles, then settles on 3
    for (int i = 0; i < 6; i++) begin
      seg_in = (i % 2 == 1) ? 7'h4F : 7'h06;
      cyc(3);
      check("t2_busy", busy, 1'b1);
      check("t2_noentry", digit_valid, 1'b0);
    end
    cyc(12);
    pop_digit(5'h03, 1'b0, "t2");
    check("t2_single", digit_valid, 1'b0);

    // T3: invalid pattern, blank, invalid again
    present(7'h49);
    pop_digit(5'h10, 1'b0, "t3a");
    present(7'h00);
    check("t3_blank", digit_valid, 1'b0);
    present(7'h49);
    pop_digit(5'h10, 1'b0, "t3b");
    check("t3_empty", digit_valid, 1'b0);

    // T4: 3,1,4,(blank),1,5 into a depth-4 FIFO without consumer
    present(7'h4F); present(7'h06); present(7'h66);
    present(7'h00); present(7'h06); present(7'h6D);
    check("t4_overflow", overflow, 1'b1);
    pop_digit(5'h03, 1'b0, "t4_0");
    pop_digit(5'h01, 1'b0, "t4_1");
    pop_digit(5'h04, 1'b0, "t4_2");
    pop_digit(5'h01, 1'b0, "t4_3");
    check("t4_empty", digit_valid, 1'b0);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    @(negedge clk);
    check("t4_clr", overflow, 1'b0);

    // T5: full FIFO, pop on the very edge the new digit is written
    present(7'h07); present(7'h7F); present(7'h6F); present(7'h77);
    seg_in = 7'h7C;
    cyc(7);
    digit_ready = 1'b1;
    @(negedge clk);
    digit_ready = 1'b0;
    check("t5_no_overflow", overflow, 1'b0);
    pop_digit(5'h08, 1'b0, "t5_0");
    pop_digit(5'h09, 1'b0, "t5_1");
    pop_digit(5'h0A, 1'b0, "t5_2");
    pop_digit(5'h0B, 1'b0, "t5_3");
    check("t5_empty", digit_valid, 1'b0);

    // T6: asynchronous reset mid-SETTLE with two queued entries
    present(7'h5B); present(7'h4F);
    seg_in = 7'h06;
    cyc(4);
    check("t6_settling", busy, 1'b1);
    check("t6_queued", digit_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", digit_valid, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_data", digit_data, 5'h00);
    seg_in = 7'h3F;
    @(negedge clk);
    #2 rst = 1'b0;
    cyc(10);
    pop_digit(5'h00, 1'b0, "t6");
    check("t6_empty", digit_valid, 1'b0);

`ifdef SEG7_DP_CAPTURE_EN
    // T7: dp-only change is a new pattern
    present(7'h00);
    present(7'h3F);
    dp_in = 1'b1;
    cyc(10);
    pop_digit(5'h00, 1'b0, "t7_0");
    pop_digit(5'h00, 1'b1, "t7_1");
    check("t7_empty", digit_valid, 1'b0);
`endif

    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_readback.md
Name: seg7_readback

Overview:
- Receive-side counterpart of the 7-segment display driver on the design's uo_out[6:0].
- Samples the raw segment pattern and waits until it is stable for a programmable dwell time.
- Decodes the stable pattern back to a hex digit and queues each new digit in a small FIFO with a valid/ready output.
- Used in-system for self-check/loopback and by benches as the display reader, in place of sampling segments directly.

Parameters:
- STABLE_CYCLES, 1000, consecutive identical samples required before a pattern is accepted; range 1..65535.
- FIFO_DEPTH, 4, decoded-digit queue depth; power of two, 2..16.
- CNT_W, 16, width of the stability counter; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- seg_in  in  7  raw segment pattern {g,f,e,d,c,b,a}, active-high.
- dp_in  in  1  decimal-point segment; used only with SEG7_DP_CAPTURE_EN.
- digit_data  out  5  {invalid, hex[3:0]}; invalid=1 means the pattern is not in the hex table (hex=0).
- digit_dp  out  1  captured decimal point; tied to 0 without the macro.
- digit_valid  out  1  FIFO head is valid.
- digit_ready  in  1  consumer accepts the head when digit_valid && digit_ready.
- overflow  out  1  sticky; set when an accepted digit is dropped because the FIFO is full.
- clr_overflow  in  1  synchronous clear of overflow.
- busy  out  1  high while the FSM is in SETTLE.

Behaviour:
- Reset values, asynchronous: digit_valid=0, digit_data=0, digit_dp=0, overflow=0, busy=0, FSM=IDLE, counter=0, FIFO empty, last_accepted=7'h00 (blank).
- Input capture: seg_in and dp_in pass through a 2-flop synchroniser. All comparisons use the synchronised value s.
- FSM states:
  - IDLE: if s != last_accepted, go to SETTLE, latch cand=s, counter=1.
  - SETTLE: if s != cand, restart with cand=s, counter=1. Otherwise counter++. When counter reaches STABLE_CYCLES, go to COMMIT.
  - COMMIT (one cycle): decode cand, push to FIFO, set last_accepted=cand, return to IDLE.
- A pattern equal to last_accepted never produces a new entry. Repeated identical digits therefore appear once.
- Transition to blank (7'h00) is accepted and updates last_accepted but is not pushed.
- Latency: input change to digit_valid = 2 (sync) + STABLE_CYCLES + 1 (COMMIT) + 1 (FIFO write) cycles, with STABLE_CYCLES counted from the first SETTLE cycle.
- Decode table, active-high segments:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
  - Any other non-blank pattern gives invalid=1, hex=0. It is still pushed.
- FIFO: first-word-fall-through; head is visible the cycle after the write.
  - Simultaneous push and pop when full: allowed, no overflow.
  - Push when full without a pop: entry dropped, overflow set.
  - Pop when empty: ignored.
- overflow: clr_overflow clears it. If clr_overflow and a new overflow occur in the same cycle, set wins.
- STABLE_CYCLES=1: COMMIT follows the first SETTLE cycle.
- Reset asserted mid-SETTLE or with a non-empty FIFO discards everything immediately.

Optional Feature:
- Macro: SEG7_DP_CAPTURE_EN.
- Defined:
  - dp_in is synchronised and joins the stability compare as an 8-bit pattern.
  - digit_dp carries the captured value.
  - A dp-only change counts as a new pattern and is pushed.
- Undefined:
  - dp_in is ignored and digit_dp=0.
  - FIFO entry width is 5 bits instead of 6.

Decomposition:
- Package seg7_pkg:
  - state enum {IDLE, SETTLE, COMMIT}
  - the 16-entry segment constant table
  - SEG_BLANK = 7'h00
  - a decode function returning {invalid, hex}
  - the digit_t struct (invalid, hex, dp)
- One sub-module, seg7_fifo: parameterised FWFT FIFO with push/full/pop/empty. The top holds the synchroniser, FSM and counter.

Test Plan:
- STABLE_CYCLES=4; seg_in=7'h5B held 10 cycles -> exactly one entry {0,4'h2}; digit_valid rises on cycle 2+4+1+1=8; a held pattern gives no second entry.
- seg_in toggles 7'h06/7'h4F every 3 cycles with STABLE_CYCLES=4, then settles on 7'h4F -> only one entry {0,4'h3}; busy high throughout the glitching.
- seg_in=7'h49 held -> entry {1,4'h0}; then 7'h00, then 7'h49 again -> a second invalid entry, with no entry for the blank.
- digit_ready=0; present 3,1,4,1,5 as distinct stable patterns (blank between the two 1s) with FIFO_DEPTH=4 -> FIFO holds 3,1,4,1; overflow=1; drain yields 3,1,4,1 in order; clr_overflow -> overflow=0.
- Full FIFO with digit_ready=1 on the same cycle a commit arrives -> no overflow; order preserved.
- rst pulsed mid-SETTLE and with 2 queued entries -> digit_valid=0 immediately (asynchronous); the next stable 7'h3F yields {0,4'h0}. With SEG7_DP_CAPTURE_EN, 7'h3F plus a dp toggle -> two entries with digit_dp 0 then 1.
